tta_fu_move_issuer: RTL
=======================

// Module: tta_fu_move_issuer
// PURPOSE
// Initiator side of the TTA function-unit port protocol: accepts whole operations (opcode, A, B) on a
// valid/ready request channel. For each one it issues the operand move (o1) and the trigger move (t1/opcode)
// to a fixed-latency FU, waits the FU latency, captures r1data and returns it on a valid/ready response channel.
// Used by the test harness and the scalar co-processor front end to drive ALU-class FUs without a full move bus.
// PARAMETERS
// DATA_W   32  width of operands and result
// OPC_W    4   width of FU opcode
// LATENCY  1   cycles from trigger-load edge to valid r1data (>=1)
// CNT_W    16  width of the completed-operation and skipped-o1-load counters
// PORTS
// clk          in   1       clock, rising edge
// reset        in   1       asynchronous, active-low reset
// req_valid    in   1       operation request valid
// req_ready    out  1       issuer can accept a request
// req_opcode   in   OPC_W   FU opcode (0=add, 9=sub, 2=eq, ...)
// req_a        in   DATA_W  trigger operand (goes to t1)
// req_b        in   DATA_W  second operand (goes to o1)
// rsp_valid    out  1       result valid
// rsp_ready    in   1       result consumer ready
// rsp_data     out  DATA_W  captured FU result
// ext_lock     in   1       global pipeline lock request
// fu_t1data    out  DATA_W  FU trigger data
// fu_t1opcode  out  OPC_W   FU trigger opcode
// fu_t1load    out  1       FU trigger load strobe
// fu_o1data    out  DATA_W  FU operand data
// fu_o1load    out  1       FU operand load strobe
// fu_r1data    in   DATA_W  FU result
// fu_glock     out  1       FU global lock (= ext_lock, combinational)
// ops_done     out  CNT_W   completed response handshakes, wraps at 2^CNT_W
// o1_skips     out  CNT_W   issues where o1 load was suppressed, wraps
// BEHAVIOUR
// - Reset (reset low, async): state IDLE; opcode/A/B/result regs 0; o1 shadow invalid; counters 0.
//   Outputs during reset: req_ready=1, rsp_valid=0, fu_*load=0, fu_*data=0, fu_t1opcode=0, rsp_data=0.
//   No request is accepted while reset is low.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: req_ready = ~ext_lock. When req_valid & req_ready at an edge, latch opcode/A/B and go to ISSUE.
// - ISSUE (one cycle unless locked):
//   - fu_t1load=1; fu_o1load = ~shadow_valid | (shadow != B).
//   - fu_t1data/fu_t1opcode/fu_o1data driven from the latched regs (those outputs always reflect the latched regs).
//   - At the edge with ext_lock=0: shadow<=B, shadow_valid<=1; o1_skips++ if fu_o1load was 0; cnt<=LATENCY-1; go to WAIT.
//   - With ext_lock=1: hold ISSUE, strobes stay high (the FU ignores them under glock).
// - WAIT: strobes 0. If ext_lock=0: when cnt==0, capture fu_r1data into rsp_data and go to RESP; otherwise cnt--.
//   If ext_lock=1: cnt holds and no capture.
//   LATENCY=1 gives exactly one WAIT cycle.
// - RESP: rsp_valid=1, rsp_data stable. On rsp_ready: ops_done++, go to IDLE.
//   The RESP handshake is not affected by ext_lock; rsp_valid never drops before the handshake.
// - Throughput: one op per 3+LATENCY cycles. req_ready=0 in ISSUE/WAIT/RESP.
// - Loads are single-cycle per issue when unlocked; no load is ever driven outside ISSUE.
// - Counters wrap modulo 2^CNT_W silently.
// - Reset mid-operation aborts the op. The FU contents are unknown, so the shadow is invalidated and the
//   next issue always loads o1.
// TESTING
// - add: opc 0, A=5, B=7, rsp_ready=1 -> t1load+o1load in cycle 1 after accept; rsp_data=12 in cycle 3; ops_done=1.
// - Reuse: op1 sub opc 9 A=10 B=3 -> 7; op2 add A=1 B=3 -> fu_o1load=0, rsp 4, o1_skips=1.
//   op3 B=4 -> o1load=1, o1_skips unchanged.
// - Lock: ext_lock high 3 cycles during ISSUE -> fu_glock high 3 cycles; loads held; response 3 cycles later;
//   result unchanged; req_ready=0 while locked in IDLE.
// - Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_data (e.g. 0xFFFFFFFF from 0-1 sub) held;
//   req_ready=0 until the handshake.
// - LATENCY=3: FU model with 3-cycle result delay, eq opc 2 A=B=9 -> rsp_data=1 exactly 3 WAIT cycles after
//   trigger; A=9 B=8 -> 0.
// - Reset asserted in WAIT -> all outputs at reset values immediately. Next op with the same B asserts fu_o1load=1;
//   ops_done=0 and o1_skips=0.

Source files
------------

// File: rtl/tta_fu_move_issuer.sv
// tta_fu_move_issuer
// Initiator side of the TTA function-unit port protocol. Takes whole operations
// (opcode, A, B) on a valid/ready request channel. For each one it issues the
// operand move (o1) and the trigger move (t1 + opcode) to a fixed-latency FU.
// It then waits out the FU latency, captures r1data and returns it on a
// valid/ready response channel.
//
// Ports
//   clk, reset                     rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_opcode/req_a/req_b         operation: A goes to t1 (trigger), B goes to o1
//   rsp_valid/rsp_ready/rsp_data   response handshake and captured FU result
//   ext_lock                       global pipeline lock request
//   fu_t1data/fu_t1opcode/fu_t1load  trigger port towards the FU
//   fu_o1data/fu_o1load            operand port towards the FU
//   fu_r1data                      FU result
//   fu_glock                       FU global lock (ext_lock passed straight through)
//   ops_done                       completed response handshakes (wrapping)
//   o1_skips                       issues whose o1 load was suppressed (wrapping)
module tta_fu_move_issuer #(
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPC_W-1:0]  req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              ext_lock,
  output logic [DATA_W-1:0] fu_t1data,
  output logic [OPC_W-1:0]  fu_t1opcode,
  output logic              fu_t1load,
  output logic [DATA_W-1:0] fu_o1data,
  output logic              fu_o1load,
  input  logic [DATA_W-1:0] fu_r1data,
  output logic              fu_glock,
  output logic [CNT_W-1:0]  ops_done,
  output logic [CNT_W-1:0]  o1_skips
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic [OPC_W-1:0]  opc_q,        opc_d;
  logic [DATA_W-1:0] a_q,          a_d;
  logic [DATA_W-1:0] b_q,          b_d;
  logic [DATA_W-1:0] shadow_q,     shadow_d;
  logic              shadow_vld_q, shadow_vld_d;
  logic [LAT_W-1:0]  cnt_q,        cnt_d;
  logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
  logic [CNT_W-1:0]  ops_done_q,   ops_done_d;
  logic [CNT_W-1:0]  o1_skips_q,   o1_skips_d;

  logic in_idle;
  logic in_issue;
  logic o1_needed;
  logic accept;

  assign in_idle  = (state_q == S_IDLE);
  assign in_issue = (state_q == S_ISSUE);

  // The shadow mirrors what the FU's o1 register holds. The o1 move is only
  // needed when that content is unknown or differs from the new B operand.
  assign o1_needed = ~shadow_vld_q | (shadow_q != b_q);
  assign accept    = req_valid & in_idle & ~ext_lock;

  // req_ready is forced high while reset is held. Acceptance is still blocked
  // because the flops are held in reset.
  assign req_ready   = ~reset | (in_idle & ~ext_lock);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_data    = rsp_data_q;
  assign fu_t1load   = in_issue;
  assign fu_o1load   = in_issue & o1_needed;
  assign fu_t1data   = a_q;
  assign fu_t1opcode = opc_q;
  assign fu_o1data   = b_q;
  assign fu_glock    = ext_lock;
  assign ops_done    = ops_done_q;
  assign o1_skips    = o1_skips_q;

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    a_d          = a_q;
    b_d          = b_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    ops_done_d   = ops_done_q;
    o1_skips_d   = o1_skips_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opc_d   = req_opcode;
          a_d     = req_a;
          b_d     = req_b;
          state_d = S_ISSUE;
        end
      end

      // Under lock the strobes stay asserted and the FU ignores them. The
      // moves only count as done on an unlocked edge.
      S_ISSUE: begin
        if (!ext_lock) begin
          shadow_d     = b_q;
          shadow_vld_d = 1'b1;
          if (!o1_needed) begin
            o1_skips_d = o1_skips_q + CNT_W'(1);
          end
          cnt_d   = LAT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end

      // The FU pipeline is frozen under lock, so the countdown freezes too.
      S_WAIT: begin
        if (!ext_lock) begin
          if (cnt_q == '0) begin
            rsp_data_d = fu_r1data;
            state_d    = S_RESP;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A reset in mid-operation leaves the FU contents unknown, so the shadow is
  // invalidated along with everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      opc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      ops_done_q   <= '0;
      o1_skips_q   <= '0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      ops_done_q   <= ops_done_d;
      o1_skips_q   <= o1_skips_d;
    end
  end

endmodule
